// File: rtl/ariane_pkg.sv
// Core-wide types and defaults shared by the decode/issue front end.
// Holds the scoreboard entry format and the default issue-queue sizing.
package ariane_pkg;

  localparam int unsigned ID_QUEUE_DEPTH   = 4;
  localparam int unsigned ID_MAX_CTRL_FLOW = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        use_imm;
    logic        valid;
  } scoreboard_entry_t;

endpackage

// File: rtl/id_issue_queue.sv
// Decode-to-issue buffer: in-order circular queue with a control-flow throttle.
// Optional zero-latency empty-queue bypass is enabled by defining ID_ISSUE_QUEUE_BYPASS_EN.
module id_issue_queue
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH         = ID_QUEUE_DEPTH,
  parameter int unsigned MAX_CTRL_FLOW = ID_MAX_CTRL_FLOW
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  scoreboard_entry_t          decoded_instr_i,
  input  logic                       is_ctrl_flow_i,
  input  logic                       decoded_valid_i,
  output logic                       decoded_ack_o,
  output scoreboard_entry_t          issue_entry_o,
  output logic                       issue_entry_valid_o,
  output logic                       is_ctrl_flow_o,
  input  logic                       issue_instr_ack_i,
  output logic [$clog2(DEPTH):0]     usage_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_CTRL_FLOW);

  scoreboard_entry_t r_mem [DEPTH];
  logic [DEPTH-1:0]  r_ctrl_mem;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_ctrl_cnt;
  logic              r_valid;

  logic              w_empty;
  logic              w_head_ctrl;
  logic              w_bypass;
  logic              w_pop;
  logic              w_pop_stored;
  logic              w_write;
  logic [CW-1:0]     w_ctrl_after_pop;
  logic [CW-1:0]     w_count_next;
  logic [CW-1:0]     w_ctrl_next;

  assign w_empty     = (r_count == '0);
  assign w_head_ctrl = r_ctrl_mem[r_rd_ptr];

`ifdef ID_ISSUE_QUEUE_BYPASS_EN
  assign w_bypass            = w_empty && decoded_valid_i && !flush_i;
  assign issue_entry_valid_o = r_valid || w_bypass;
  assign issue_entry_o       = w_bypass ? decoded_instr_i : r_mem[r_rd_ptr];
  assign is_ctrl_flow_o      = w_bypass ? is_ctrl_flow_i : w_head_ctrl;
`else
  assign w_bypass            = 1'b0;
  assign issue_entry_valid_o = r_valid;
  assign issue_entry_o       = r_mem[r_rd_ptr];
  assign is_ctrl_flow_o      = w_head_ctrl;
`endif

  // A bypassed pop never touches storage, so only stored pops move the read side.
  assign w_pop            = issue_instr_ack_i && issue_entry_valid_o;
  assign w_pop_stored     = w_pop && !w_empty;
  assign w_ctrl_after_pop = r_ctrl_cnt - CW'(w_pop_stored && w_head_ctrl);

  assign decoded_ack_o = decoded_valid_i && !flush_i
                         && ((r_count < DEPTH_C) || w_pop)
                         && (!is_ctrl_flow_i || (w_ctrl_after_pop < MAX_C));

  assign w_write      = decoded_ack_o && !(w_bypass && w_pop);
  assign w_count_next = r_count + CW'(w_write) - CW'(w_pop_stored);
  assign w_ctrl_next  = r_ctrl_cnt + CW'(w_write && is_ctrl_flow_i)
                        - CW'(w_pop_stored && w_head_ctrl);

  assign usage_o = r_count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_ctrl_cnt <= '0;
      r_valid    <= 1'b0;
      r_ctrl_mem <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush_i) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_ctrl_cnt <= '0;
      r_valid    <= 1'b0;
    end else begin
      if (w_write) begin
        r_mem[r_wr_ptr]      <= decoded_instr_i;
        r_ctrl_mem[r_wr_ptr] <= is_ctrl_flow_i;
        r_wr_ptr             <= r_wr_ptr + PW'(1);
      end
      if (w_pop_stored) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count    <= w_count_next;
      r_ctrl_cnt <= w_ctrl_next;
      r_valid    <= (w_count_next != '0);
    end
  end

`ifndef SYNTHESIS
  a_depth_pow2: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0));
  a_max_ctrl_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (MAX_CTRL_FLOW >= 1) && (MAX_CTRL_FLOW <= DEPTH));
  a_no_ack_invalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(issue_instr_ack_i && !issue_entry_valid_o));
  a_ctrl_le_count: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_ctrl_cnt <= r_count);
`endif

endmodule

// File: tb/tb_id_issue_queue.sv
// Self-checking bench for id_issue_queue: directed plan steps plus random traffic
// compared against a queue-based reference model.
module tb_id_issue_queue;
  import ariane_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXC  = 2;
`ifdef ID_ISSUE_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              flush_i;
  scoreboard_entry_t decoded_instr_i;
  logic              is_ctrl_flow_i;
  logic              decoded_valid_i;
  logic              decoded_ack_o;
  scoreboard_entry_t issue_entry_o;
  logic              issue_entry_valid_o;
  logic              is_ctrl_flow_o;
  logic              issue_instr_ack_i;
  logic [2:0]        usage_o;

  id_issue_queue #(.DEPTH(DEPTH), .MAX_CTRL_FLOW(MAXC)) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .flush_i             (flush_i),
    .decoded_instr_i     (decoded_instr_i),
    .is_ctrl_flow_i      (is_ctrl_flow_i),
    .decoded_valid_i     (decoded_valid_i),
    .decoded_ack_o       (decoded_ack_o),
    .issue_entry_o       (issue_entry_o),
    .issue_entry_valid_o (issue_entry_valid_o),
    .is_ctrl_flow_o      (is_ctrl_flow_o),
    .issue_instr_ack_i   (issue_instr_ack_i),
    .usage_o             (usage_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    scoreboard_entry_t e;
    bit                c;
  } item_t;

  item_t q[$];
  int    checks   = 0;
  int    failures = 0;
  bit    acked;
  int    nxt;

  function automatic scoreboard_entry_t mk(input int pc);
    scoreboard_entry_t e;
    e.pc      = pc;
    e.op      = 8'($urandom);
    e.rs1     = 5'($urandom);
    e.rs2     = 5'($urandom);
    e.rd      = 5'($urandom);
    e.result  = $urandom;
    e.use_imm = 1'($urandom);
    e.valid   = 1'b1;
    return e;
  endfunction

  function automatic int model_ctrl();
    int n = 0;
    foreach (q[i]) if (q[i].c) n++;
    return n;
  endfunction

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_usage(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_entry(input string tag, input scoreboard_entry_t obs, input scoreboard_entry_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive, check combinational and registered outputs, then advance the model.
  task automatic cycle(input bit v, input bit c, input scoreboard_entry_t e,
                       input bit a, input bit f, output bit ok);
    bit exp_valid, exp_ack, pop;
    int nctrl;
    exp_valid = (q.size() > 0) || (BYPASS && v && !f);
    decoded_valid_i   = v;
    is_ctrl_flow_i    = c;
    decoded_instr_i   = e;
    flush_i           = f;
    issue_instr_ack_i = a && exp_valid;
    pop   = a && exp_valid;
    nctrl = model_ctrl() - ((pop && q.size() > 0 && q[0].c) ? 1 : 0);
    exp_ack = v && !f && (q.size() < DEPTH || pop) && (!c || nctrl < MAXC);
    #2;
    chk_bit("decoded_ack", decoded_ack_o, exp_ack);
    chk_bit("issue_valid", issue_entry_valid_o, exp_valid);
    chk_usage("usage", usage_o, 3'(q.size()));
    if (exp_valid) begin
      if (q.size() > 0) begin
        chk_entry("head_entry", issue_entry_o, q[0].e);
        chk_bit("head_ctrl", is_ctrl_flow_o, q[0].c);
      end else begin
        chk_entry("bypass_entry", issue_entry_o, e);
        chk_bit("bypass_ctrl", is_ctrl_flow_o, c);
      end
    end
    @(posedge clk_i);
    #1;
    if (f) begin
      q.delete();
    end else if (!(q.size() == 0 && pop && exp_ack)) begin
      if (pop) void'(q.pop_front());
      if (exp_ack) q.push_back('{e: e, c: c});
    end
    ok = exp_ack;
  endtask

  task automatic idle_inputs();
    decoded_valid_i   = 1'b0;
    is_ctrl_flow_i    = 1'b0;
    decoded_instr_i   = '0;
    flush_i           = 1'b0;
    issue_instr_ack_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_bit({tag, "_valid"}, issue_entry_valid_o, 1'b0);
    chk_usage({tag, "_usage"}, usage_o, 3'd0);
    chk_bit({tag, "_ctrl"}, is_ctrl_flow_o, 1'b0);
    chk_entry({tag, "_entry"}, issue_entry_o, '0);
    chk_bit({tag, "_ack"}, decoded_ack_o, 1'b0);
  endtask

  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Fill with six back-to-back entries and no issue acks, then one ack.
    nxt = 100;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, mk(nxt), 1'b0, 1'b0, acked);
      if (acked) nxt++;
    end
    cycle(1'b1, 1'b0, mk(nxt), 1'b1, 1'b0, acked);
    if (acked) nxt++;
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, acked);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, acked);

    // Three held, then ten cycles of simultaneous push and pop across pointer wraps.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, mk(200 + i), 1'b0, 1'b0, acked);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, mk(210 + i), 1'b1, 1'b0, acked);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, acked);

    // Control-flow throttle: third ctrl stalls until the ctrl head drains.
    cycle(1'b1, 1'b1, mk(300), 1'b0, 1'b0, acked);
    cycle(1'b1, 1'b1, mk(301), 1'b0, 1'b0, acked);
    cycle(1'b1, 1'b1, mk(302), 1'b0, 1'b0, acked);
    cycle(1'b1, 1'b1, mk(302), 1'b1, 1'b0, acked);
    cycle(1'b1, 1'b0, mk(303), 1'b0, 1'b0, acked);
    for (int i = 0; i < 8 && q.size() > 0; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, acked);

    // Flush with valid input and issue ack both asserted.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, mk(400 + i), 1'b0, 1'b0, acked);
    cycle(1'b1, 1'b0, mk(403), 1'b1, 1'b1, acked);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, acked);

    // Empty queue with a valid input and a same-cycle issue ack.
    cycle(1'b1, 1'b1, mk(500), 1'b1, 1'b0, acked);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, acked);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, acked);

    // Asynchronous reset in the middle of a cycle with two entries held.
    cycle(1'b1, 1'b1, mk(600), 1'b0, 1'b0, acked);
    cycle(1'b1, 1'b0, mk(601), 1'b0, 1'b0, acked);
    idle_inputs();
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("midreset");
    q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    cycle(1'b1, 1'b0, mk(700), 1'b0, 1'b0, acked);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, acked);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, acked);

    // Random traffic against the reference queue.
    nxt = 1000;
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, mk(nxt),
            1'($urandom_range(0, 1)), $urandom_range(0, 30) == 0, acked);
      nxt++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
